// File: rtl/mvu_stream_pkg.sv
// Shared constants, types and FSM encoding for the MVU weight streamer.
// Default geometry matches the mvu_vvu_axi build that consumes the stream.
package mvu_stream_pkg;

    localparam int MW           = 50;
    localparam int MH           = 4;
    localparam int SIMD         = 25;
    localparam int PE           = 2;
    localparam int WEIGHT_WIDTH = 4;
    localparam int N_REPS       = 3;

    localparam int NF    = MH / PE;
    localparam int SF    = MW / SIMD;
    localparam int DEPTH = NF * SF;
    localparam int WW    = PE * SIMD * WEIGHT_WIDTH;
    localparam int WW_BA = (WW + 7) / 8 * 8;

    typedef logic [PE-1:0][SIMD-1:0][WEIGHT_WIDTH-1:0] weight_word_t;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_e;

endpackage

// File: rtl/mvu_weight_streamer_skid_fifo2.sv
// Two-entry valid/ready buffer. o_credit tells the producer whether a word
// launched this cycle (arriving next cycle) is guaranteed a free slot.
module skid_fifo2 #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_credit,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    input  logic             i_ready
);

    logic [1:0]       r_cnt;
    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic             w_pop;
    logic [2:0]       w_occ_next;

    assign o_valid = (r_cnt != 2'd0);
    assign o_data  = r_head;
    assign w_pop   = o_valid & i_ready;

    // Credit counts the word already in flight and the pop happening now.
    always_comb begin
        w_occ_next = {1'b0, r_cnt} + {2'b00, i_valid} - {2'b00, w_pop};
        o_credit   = (w_occ_next < 3'd2);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt  <= 2'd0;
            r_head <= '0;
            r_tail <= '0;
        end else begin
            case ({i_valid, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) begin
                        r_head <= i_data;
                        r_cnt  <= r_cnt + 2'd1;
                    end else if (r_cnt == 2'd1) begin
                        r_tail <= i_data;
                        r_cnt  <= r_cnt + 2'd1;
                    end
                end
                2'b01: begin
                    r_head <= r_tail;
                    r_cnt  <= r_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_cnt == 2'd2) begin
                        r_head <= r_tail;
                        r_tail <= i_data;
                    end else begin
                        r_head <= i_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mvu_weight_streamer.sv
// Stores one weight matrix from a load stream and replays it N_REPS times
// (nf outer, sf inner) as the weight AXI-Stream for mvu_vvu_axi.
module mvu_weight_streamer #(
    parameter int MW           = mvu_stream_pkg::MW,
    parameter int MH           = mvu_stream_pkg::MH,
    parameter int SIMD         = mvu_stream_pkg::SIMD,
    parameter int PE           = mvu_stream_pkg::PE,
    parameter int WEIGHT_WIDTH = mvu_stream_pkg::WEIGHT_WIDTH,
    parameter int N_REPS       = mvu_stream_pkg::N_REPS,
    localparam int NF          = MH / PE,
    localparam int SF          = MW / SIMD,
    localparam int DEPTH       = NF * SF,
    localparam int WW          = PE * SIMD * WEIGHT_WIDTH,
    localparam int WW_BA       = (WW + 7) / 8 * 8
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    input  logic [WW_BA-1:0] s_axis_wload_tdata,
    input  logic             s_axis_wload_tvalid,
    output logic             s_axis_wload_tready,
    output logic [WW_BA-1:0] m_axis_weights_tdata,
    output logic             m_axis_weights_tvalid,
    input  logic             m_axis_weights_tready,
    output logic             busy
);

    import mvu_stream_pkg::*;

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int RW = (N_REPS > 1) ? $clog2(N_REPS + 1) : 1;

    state_e         r_state;
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [RW-1:0]  r_rep_cnt;
    logic [WW-1:0]  r_mem [DEPTH];
    logic [WW-1:0]  r_rd_data;
    logic           r_rd_vld;

    logic           w_load_fire;
    logic           w_rd_en;
    logic           w_rd_wrap;
    logic           w_wr_wrap;
    logic           w_last_rep;
    logic           w_credit;
    logic           w_fifo_valid;
    logic [WW-1:0]  w_fifo_data;

    assign s_axis_wload_tready = (r_state == LOAD) && !ap_rst;
    assign w_load_fire         = s_axis_wload_tready && s_axis_wload_tvalid;
    assign w_rd_en             = (r_state == STREAM) && w_credit;
    assign w_wr_wrap           = (r_wr_ptr == PW'(DEPTH - 1));
    assign w_rd_wrap           = (r_rd_ptr == PW'(DEPTH - 1));
    assign w_last_rep          = (N_REPS != 0) && (int'(r_rep_cnt) + 1 == N_REPS);
    assign busy                = (r_state == STREAM) || w_fifo_valid;

    always_ff @(posedge ap_clk) begin
        if (w_load_fire) begin
            r_mem[r_wr_ptr] <= s_axis_wload_tdata[WW-1:0];
        end
        if (w_rd_en) begin
            r_rd_data <= r_mem[r_rd_ptr];
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state   <= LOAD;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_rep_cnt <= '0;
            r_rd_vld  <= 1'b0;
        end else begin
            r_rd_vld <= w_rd_en;
            case (r_state)
                LOAD: begin
                    if (w_load_fire) begin
                        if (w_wr_wrap) begin
                            r_wr_ptr <= '0;
                            r_state  <= STREAM;
                        end else begin
                            r_wr_ptr <= r_wr_ptr + 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (w_rd_en) begin
                        if (w_rd_wrap) begin
                            r_rd_ptr  <= '0;
                            r_rep_cnt <= r_rep_cnt + 1'b1;
                            if (w_last_rep) begin
                                r_state <= DRAIN;
                            end
                        end else begin
                            r_rd_ptr <= r_rd_ptr + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    r_rep_cnt <= '0;
                    if (!w_fifo_valid && !r_rd_vld) begin
                        r_state <= LOAD;
                    end
                end
                default: r_state <= LOAD;
            endcase
        end
    end

    skid_fifo2 #(
        .WIDTH (WW)
    ) u_skid (
        .i_clk    (ap_clk),
        .i_rst    (ap_rst),
        .i_valid  (r_rd_vld),
        .i_data   (r_rd_data),
        .o_credit (w_credit),
        .o_valid  (w_fifo_valid),
        .o_data   (w_fifo_data),
        .i_ready  (m_axis_weights_tready)
    );

    assign m_axis_weights_tvalid = w_fifo_valid;

    always_comb begin
        m_axis_weights_tdata         = '0;
        m_axis_weights_tdata[WW-1:0] = w_fifo_data;
    end

endmodule

// File: tb/tb_mvu_weight_streamer.sv
// Directed bench for mvu_weight_streamer: a 3-replay instance and a
// replay-forever instance sharing clock and reset.
module tb_mvu_weight_streamer;

    localparam int WW_BA = 200;

    logic             clk;
    logic             rst;
    logic [WW_BA-1:0] wl_tdata;
    logic             wl_tvalid;
    logic             wl_tready;
    logic [WW_BA-1:0] m_tdata;
    logic             m_tvalid;
    logic             m_tready;
    logic             busy;

    logic [WW_BA-1:0] z_wdata;
    logic             z_wvalid;
    logic             z_wready;
    logic [WW_BA-1:0] z_tdata;
    logic             z_tvalid;
    logic             z_tready;
    logic             z_busy;

    int checks = 0;
    int errors = 0;

    mvu_weight_streamer #(
        .N_REPS (3)
    ) dut (
        .ap_clk                (clk),
        .ap_rst                (rst),
        .s_axis_wload_tdata    (wl_tdata),
        .s_axis_wload_tvalid   (wl_tvalid),
        .s_axis_wload_tready   (wl_tready),
        .m_axis_weights_tdata  (m_tdata),
        .m_axis_weights_tvalid (m_tvalid),
        .m_axis_weights_tready (m_tready),
        .busy                  (busy)
    );

    mvu_weight_streamer #(
        .N_REPS (0)
    ) dut0 (
        .ap_clk                (clk),
        .ap_rst                (rst),
        .s_axis_wload_tdata    (z_wdata),
        .s_axis_wload_tvalid   (z_wvalid),
        .s_axis_wload_tready   (z_wready),
        .m_axis_weights_tdata  (z_tdata),
        .m_axis_weights_tvalid (z_tvalid),
        .m_axis_weights_tready (z_tready),
        .busy                  (z_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Loads base..base+3; called and returns on a negedge (the cycle after the last write).
    task automatic load_words(input int base, input int gap, output logic busy_at_last);
        int to;
        busy_at_last = 1'bx;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                for (int g = 1; g < gap; g++) @(negedge clk);
            end
            to = 0;
            while (wl_tready !== 1'b1 && to < 50) begin
                @(negedge clk);
                to++;
            end
            if (to >= 50) begin
                checks++;
                errors++;
                $display("FAIL load_wait: wload_tready=%b required 1 within 50 cycles", wl_tready);
            end
            wl_tvalid = 1'b1;
            wl_tdata  = WW_BA'(base + i);
            busy_at_last = busy;
            @(negedge clk);
            wl_tvalid = 1'b0;
            wl_tdata  = '0;
        end
    endtask

    task automatic collect(input int base, input int n, input bit alt, input string tag);
        int idx = 0;
        int cyc = 0;
        int bubbles = 0;
        bit started = 1'b0;
        bit ph = 1'b1;
        bit prev_hold = 1'b0;
        logic [WW_BA-1:0] prev_data = '0;
        logic [WW_BA-1:0] exp_w;
        while (idx < n && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (prev_hold) begin
                checks++;
                if (m_tvalid !== 1'b1 || m_tdata !== prev_data) begin
                    errors++;
                    $display("FAIL %s_hold: valid=%b data=%h required valid=1 data=%h",
                             tag, m_tvalid, m_tdata, prev_data);
                end
            end
            if (!alt && started && m_tvalid !== 1'b1) bubbles++;
            m_tready = alt ? ph : 1'b1;
            ph = ~ph;
            if (m_tvalid === 1'b1) started = 1'b1;
            if (m_tvalid === 1'b1 && m_tready) begin
                exp_w = WW_BA'(base + idx % 4);
                checks++;
                if (m_tdata !== exp_w) begin
                    errors++;
                    $display("FAIL %s_word%0d: got %h required %h", tag, idx, m_tdata, exp_w);
                end
                idx++;
            end
            prev_hold = (m_tvalid === 1'b1) && !m_tready;
            prev_data = m_tdata;
        end
        checks++;
        if (idx != n) begin
            errors++;
            $display("FAIL %s_count: got %0d words required %0d", tag, idx, n);
        end
        if (!alt) begin
            checks++;
            if (bubbles != 0) begin
                errors++;
                $display("FAIL %s_bubbles: got %0d required 0", tag, bubbles);
            end
        end
    endtask

    task automatic check_drained(input string tag);
        int to = 0;
        @(negedge clk);
        checks++;
        if (m_tvalid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle: tvalid=%b busy=%b required 0 0", tag, m_tvalid, busy);
        end
        while (wl_tready !== 1'b1 && to < 5) begin
            @(negedge clk);
            to++;
        end
        checks++;
        if (wl_tready !== 1'b1) begin
            errors++;
            $display("FAIL %s_reload_ready: wload_tready=%b required 1", tag, wl_tready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wl_tvalid = 1'b0; wl_tdata = '0; m_tready = 1'b0;
        z_wvalid = 1'b0;  z_wdata = '0;  z_tready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (m_tvalid !== 1'b0 || m_tdata !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: tvalid=%b tdata=%h busy=%b required 0 0 0", m_tvalid, m_tdata, busy);
        end
        checks++;
        if (wl_tready !== 1'b0) begin
            errors++;
            $display("FAIL reset_wready: got %b required 0", wl_tready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (wl_tready !== 1'b1 || z_wready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_wready: got %b %b required 1 1", wl_tready, z_wready);
        end
    endtask

    task automatic test_stream_full();
        logic lb;
        m_tready = 1'b1;
        load_words(1, 1, lb);
        collect(1, 12, 1'b0, "full");
        check_drained("full");
    endtask

    task automatic test_alt_ready();
        logic lb;
        load_words(1, 1, lb);
        collect(1, 12, 1'b1, "alt");
        check_drained("alt");
    endtask

    task automatic test_stall();
        logic lb;
        int rdc = 0;
        m_tready = 1'b0;
        load_words(1, 1, lb);
        for (int k = 0; k < 20; k++) begin
            if (dut.w_rd_en === 1'b1) rdc++;
            @(negedge clk);
        end
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== WW_BA'(1)) begin
            errors++;
            $display("FAIL stall_head: tvalid=%b tdata=%h required 1 %h", m_tvalid, m_tdata, WW_BA'(1));
        end
        checks++;
        if (rdc > 2) begin
            errors++;
            $display("FAIL stall_reads: got %0d reads required <= 2", rdc);
        end
        collect(1, 12, 1'b0, "stall");
        check_drained("stall");
    endtask

    task automatic test_reset_mid();
        logic lb;
        m_tready = 1'b1;
        load_words(1, 1, lb);
        collect(1, 5, 1'b0, "mid");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (m_tvalid !== 1'b0 || busy !== 1'b0 || wl_tready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_out: tvalid=%b busy=%b wready=%b required 0 0 0", m_tvalid, busy, wl_tready);
        end
        rst = 1'b0;
        #1;
        load_words(16'hA, 1, lb);
        collect(16'hA, 12, 1'b0, "reload");
        check_drained("reload");
    endtask

    task automatic test_gapped_load();
        logic lb;
        m_tready = 1'b0;
        load_words(16'h11, 3, lb);
        checks++;
        if (lb !== 1'b0) begin
            errors++;
            $display("FAIL gap_pre_busy: got %b required 0", lb);
        end
        checks++;
        if (busy !== 1'b1 || wl_tready !== 1'b0 || m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL gap_stream_entry: busy=%b wready=%b tvalid=%b required 1 0 0", busy, wl_tready, m_tvalid);
        end
        @(negedge clk);
        checks++;
        if (m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL gap_lat1: tvalid=%b required 0", m_tvalid);
        end
        @(negedge clk);
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== WW_BA'(16'h11)) begin
            errors++;
            $display("FAIL gap_lat2: tvalid=%b tdata=%h required 1 %h", m_tvalid, m_tdata, WW_BA'(16'h11));
        end
        collect(16'h11, 12, 1'b0, "gap");
        check_drained("gap");
    endtask

    task automatic test_nreps0();
        int idx = 0;
        bit started = 1'b0;
        logic [WW_BA-1:0] exp_w;
        for (int i = 0; i < 4; i++) begin
            z_wvalid = 1'b1;
            z_wdata  = WW_BA'(i + 1);
            @(negedge clk);
        end
        z_wvalid = 1'b0;
        z_wdata  = '0;
        z_tready = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            checks++;
            if (z_wready !== 1'b0) begin
                errors++;
                $display("FAIL rep0_wready c%0d: got %b required 0", c, z_wready);
            end
            if (z_tvalid === 1'b1) started = 1'b1;
            if (started) begin
                exp_w = WW_BA'(1 + idx % 4);
                checks++;
                if (z_tvalid !== 1'b1 || z_tdata !== exp_w) begin
                    errors++;
                    $display("FAIL rep0_word%0d: tvalid=%b tdata=%h required 1 %h", idx, z_tvalid, z_tdata, exp_w);
                end
                idx++;
            end
        end
        checks++;
        if (idx < 990) begin
            errors++;
            $display("FAIL rep0_count: got %0d words required >= 990", idx);
        end
    endtask

    initial begin
        test_reset();
        test_stream_full();
        test_alt_ready();
        test_stall();
        test_reset_mid();
        test_gapped_load();
        test_nreps0();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish within time budget");
        $fatal(1, "timeout");
    end

endmodule
